// File: rtl/instr_fetch_queue.sv
// Instruction fetch stage: sequential fetch over a req/ack memory port into a small
// {pc, word} FIFO presented to decode with valid/ready; redirects flush and refetch.
module instr_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_data_o,
  output logic [31:0] inst_pc_o,
  input  logic        inst_ready_i
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);
  localparam logic [PtrW-1:0] PtrOne  = PtrW'(1);

  typedef enum logic [1:0] {StIdle, StReq, StDiscard} state_e;

  state_e            state_q, state_d;
  logic [31:0]       fetch_pc_q, fetch_pc_d;
  logic [31:0]       discard_addr_q, discard_addr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [31:0]       pc_mem_q   [DEPTH];
  logic [31:0]       data_mem_q [DEPTH];

  logic              push;
  logic              pop;
  logic [31:0]       redirect_target;
  logic [1:0]        unused_redirect_lsb;

  assign redirect_target     = {redirect_pc_i[31:2], 2'b00};
  assign unused_redirect_lsb = redirect_pc_i[1:0];

  assign push = (state_q == StReq) && mem_ack_i && !redirect_i;
  assign pop  = (count_q != '0) && inst_ready_i && !redirect_i;

  // Datapath next-state: occupancy, pointers and fetch address.
  always_comb begin
    count_d        = count_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    fetch_pc_d     = fetch_pc_q;
    discard_addr_d = discard_addr_q;
    if (redirect_i) begin
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      fetch_pc_d = redirect_target;
      // Remember the abandoned address so mem_addr stays stable while draining.
      if ((state_q == StReq) && !mem_ack_i) begin
        discard_addr_d = fetch_pc_q;
      end
    end else begin
      unique case ({push, pop})
        2'b10:   count_d = count_q + CntOne;
        2'b01:   count_d = count_q - CntOne;
        default: count_d = count_q;
      endcase
      if (push) begin
        wr_ptr_d   = wr_ptr_q + PtrOne;
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrOne;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q        <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      fetch_pc_q     <= RESET_PC;
      discard_addr_q <= '0;
    end else begin
      count_q        <= count_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      fetch_pc_q     <= fetch_pc_d;
      discard_addr_q <= discard_addr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem_q[wr_ptr_q]   <= fetch_pc_q;
      data_mem_q[wr_ptr_q] <= mem_rdata_i;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    if (redirect_i) begin
      if ((state_q != StIdle) && !mem_ack_i) begin
        state_d = StDiscard;
      end else begin
        state_d = StReq;
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          if (count_d < CntFull) state_d = StReq;
        end
        StReq: begin
          if (mem_ack_i) state_d = (count_d < CntFull) ? StReq : StIdle;
        end
        StDiscard: begin
          if (mem_ack_i) state_d = StReq;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // FSM outputs.
  always_comb begin
    mem_req_o  = (state_q != StIdle);
    mem_addr_o = (state_q == StDiscard) ? discard_addr_q : fetch_pc_q;
  end

  assign inst_valid_o = (count_q != '0);
  assign inst_data_o  = inst_valid_o ? data_mem_q[rd_ptr_q] : '0;
  assign inst_pc_o    = inst_valid_o ? pc_mem_q[rd_ptr_q] : '0;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue: stream, back-pressure, latency, redirects,
// address wrap and mid-request reset, with hand-computed expectations.
module tb_instr_fetch_queue;

  localparam logic [31:0] Key = 32'hC0DE_0000;

  logic        clk;
  logic        rst;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_ready;

  int total = 0;
  int bad   = 0;

  instr_fetch_queue #(
    .DEPTH    (4),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .mem_req_o     (mem_req),
    .mem_addr_o    (mem_addr),
    .mem_ack_i     (mem_ack),
    .mem_rdata_i   (mem_rdata),
    .inst_valid_o  (inst_valid),
    .inst_data_o   (inst_data),
    .inst_pc_o     (inst_pc),
    .inst_ready_i  (inst_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: each word is its address tagged with a fixed key.
  assign mem_rdata = mem_addr ^ Key;

  function automatic logic [31:0] dat(input logic [31:0] a);
    return a ^ Key;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    redirect   = 1'b0;
    mem_ack    = 1'b0;
    inst_ready = 1'b0;
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    rst         = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    mem_ack     = 1'b0;
    inst_ready  = 1'b0;
    cyc();
    cyc();
    chk1("rst_req", mem_req, 1'b0);
    chk1("rst_valid", inst_valid, 1'b0);
    chk32("rst_data", inst_data, 32'h0);
    chk32("rst_pc", inst_pc, 32'h0);

    // Zero-wait stream with a ready consumer.
    rst        = 1'b0;
    mem_ack    = 1'b1;
    inst_ready = 1'b1;
    chk1("s_c0_req", mem_req, 1'b0);
    cyc();
    chk1("s_c1_req", mem_req, 1'b1);
    chk32("s_c1_addr", mem_addr, 32'h0);
    chk1("s_c1_valid", inst_valid, 1'b0);
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk32("s_addr", mem_addr, 32'((i + 1) * 4));
      chk1("s_valid", inst_valid, 1'b1);
      chk32("s_pc", inst_pc, 32'(i * 4));
      chk32("s_data", inst_data, dat(32'(i * 4)));
    end

    // Back-pressure: fills to four entries then stops requesting.
    do_reset();
    mem_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk1("bp_req", mem_req, 1'b1);
      chk32("bp_addr", mem_addr, 32'(i * 4));
    end
    cyc();
    chk1("bp_full_req", mem_req, 1'b0);
    chk1("bp_full_valid", inst_valid, 1'b1);
    chk32("bp_full_pc", inst_pc, 32'h0);
    cyc();
    chk1("bp_hold_req", mem_req, 1'b0);
    chk32("bp_hold_pc", inst_pc, 32'h0);
    inst_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk1("bp_drain_req", mem_req, 1'b1);
      chk32("bp_drain_addr", mem_addr, 32'(16 + i * 4));
      chk32("bp_drain_pc", inst_pc, 32'(4 + i * 4));
    end

    // Variable latency: address held stable across wait cycles.
    do_reset();
    inst_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk1("vl_req", mem_req, 1'b1);
      chk32("vl_addr", mem_addr, 32'h0);
      chk1("vl_valid", inst_valid, 1'b0);
    end
    cyc();
    chk32("vl_addr_last", mem_addr, 32'h0);
    mem_ack = 1'b1;
    cyc();
    chk1("vl_got_valid", inst_valid, 1'b1);
    chk32("vl_got_pc", inst_pc, 32'h0);
    chk32("vl_next_addr", mem_addr, 32'h4);
    mem_ack = 1'b0;
    cyc();
    chk1("vl_empty", inst_valid, 1'b0);
    chk32("vl_wait_addr", mem_addr, 32'h4);
    cyc();
    cyc();
    chk32("vl_wait_addr2", mem_addr, 32'h4);
    mem_ack = 1'b1;
    cyc();
    chk32("vl_pc2", inst_pc, 32'h4);
    chk32("vl_addr3", mem_addr, 32'h8);
    mem_ack = 1'b0;

    // Redirect while a request is outstanding: response drained and dropped.
    do_reset();
    inst_ready  = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h20;
    cyc();
    chk1("rd_req", mem_req, 1'b1);
    chk32("rd_addr", mem_addr, 32'h20);
    redirect_pc = 32'h103;
    cyc();
    redirect = 1'b0;
    chk1("rd_disc_req", mem_req, 1'b1);
    chk32("rd_disc_addr", mem_addr, 32'h20);
    chk1("rd_disc_valid", inst_valid, 1'b0);
    cyc();
    chk32("rd_disc_addr2", mem_addr, 32'h20);
    mem_ack = 1'b1;
    cyc();
    chk32("rd_new_addr", mem_addr, 32'h100);
    chk1("rd_dropped", inst_valid, 1'b0);
    cyc();
    chk1("rd_valid", inst_valid, 1'b1);
    chk32("rd_pc", inst_pc, 32'h100);
    chk32("rd_data", inst_data, dat(32'h100));
    chk32("rd_addr2", mem_addr, 32'h104);
    inst_ready = 1'b0;
    cyc();
    chk32("fill_addr", mem_addr, 32'h108);
    cyc();
    chk32("fill_head", inst_pc, 32'h100);
    chk32("fill_addr2", mem_addr, 32'h10C);

    // Redirect coincident with ack and pop, three entries queued.
    redirect    = 1'b1;
    redirect_pc = 32'h40;
    inst_ready  = 1'b1;
    cyc();
    redirect = 1'b0;
    mem_ack  = 1'b0;
    chk1("co_valid", inst_valid, 1'b0);
    chk1("co_req", mem_req, 1'b1);
    chk32("co_addr", mem_addr, 32'h40);
    cyc();
    chk1("co_valid2", inst_valid, 1'b0);
    mem_ack = 1'b1;
    cyc();
    chk32("co_pc", inst_pc, 32'h40);
    chk32("co_addr2", mem_addr, 32'h44);

    // Address wrap at the top of the space.
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    cyc();
    redirect = 1'b0;
    chk1("wr_valid", inst_valid, 1'b0);
    chk32("wr_addr", mem_addr, 32'hFFFF_FFFC);
    cyc();
    chk32("wr_pc", inst_pc, 32'hFFFF_FFFC);
    chk32("wr_data", inst_data, dat(32'hFFFF_FFFC));
    chk32("wr_addr0", mem_addr, 32'h0);
    cyc();
    chk32("wr_pc0", inst_pc, 32'h0);
    chk32("wr_addr4", mem_addr, 32'h4);
    mem_ack = 1'b0;

    // Reset during a wait; late ack must not be taken.
    cyc();
    chk32("mr_wait_addr", mem_addr, 32'h4);
    rst     = 1'b1;
    mem_ack = 1'b1;
    cyc();
    chk1("mr_req", mem_req, 1'b0);
    chk1("mr_valid", inst_valid, 1'b0);
    chk32("mr_addr", mem_addr, 32'h0);
    rst = 1'b0;
    cyc();
    chk1("mr_req2", mem_req, 1'b1);
    chk32("mr_addr2", mem_addr, 32'h0);
    chk1("mr_late_ignored", inst_valid, 1'b0);
    cyc();
    chk1("mr_valid2", inst_valid, 1'b1);
    chk32("mr_pc", inst_pc, 32'h0);
    chk32("mr_data", inst_data, dat(32'h0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_fetch_queue.md
# instr_fetch_queue

Instruction fetch stage sitting between the program counter and the decode/control logic of the RISC processor. It fetches sequential instruction words from a variable-latency instruction memory over a req/ack handshake and buffers them in a small FIFO. It presents each instruction with its PC to decode over a valid/ready handshake. A branch redirect flushes the queue and restarts fetch at a new address, dropping any in-flight response.

## Interface
- DEPTH, 4: FIFO entries, power of two, at least 2
- RESET_PC, 32'h0000_0000: first fetch address after reset, word aligned
- clk  in  1  clock, all logic on posedge
- rst  in  1  reset, synchronous, active-high
- redirect  in  1  taken branch/jump; flush and refetch from redirect_pc
- redirect_pc  in  32  new byte address; bits [1:0] ignored and forced to 00
- mem_req  out  1  instruction memory request
- mem_addr  out  32  byte address of requested word
- mem_ack  in  1  memory returns data this cycle; valid only while mem_req=1
- mem_rdata  in  32  instruction word, sampled when mem_req & mem_ack
- inst_valid  out  1  queue head valid
- inst_data  out  32  head instruction
- inst_pc  out  32  byte address of head instruction
- inst_ready  in  1  decode consumes head when inst_valid & inst_ready

## Operation
- State register holds IDLE, REQ or DISCARD. Also: fetch_pc (32), FIFO storage of {pc, word}, and count (0..DEPTH).
- mem_req = (state != IDLE). mem_addr = fetch_pc in REQ. In DISCARD, mem_addr holds the abandoned address.
- Only one request is outstanding at a time. mem_req and mem_addr stay stable until mem_ack. An ack in the same cycle as the request is allowed.
- Push: in REQ with mem_ack and no redirect, enqueue {fetch_pc, mem_rdata} and set fetch_pc += 4. fetch_pc wraps modulo 2^32.
- Pop: when inst_valid & inst_ready and no redirect.
- count_next = count + push − pop. Simultaneous push and pop leaves count unchanged.
- Transitions without redirect:
  - IDLE → REQ when count_next < DEPTH.
  - REQ with ack → REQ if count_next < DEPTH, else IDLE. This allows back-to-back requests.
  - REQ without ack → REQ.
- Invariant: count + outstanding ≤ DEPTH, so an ack never arrives while the FIFO is full.
- Redirect takes priority over push, pop and all transitions:
  - FIFO emptied (count_next = 0); fetch_pc ← {redirect_pc[31:2], 2'b00}.
  - If state is REQ or DISCARD and mem_ack = 0 that cycle: next state DISCARD (the outstanding response must be drained).
  - Otherwise (IDLE, or acked this cycle, where the acked data is dropped): next state REQ.
- DISCARD with mem_ack: data dropped, next state REQ using the already-updated fetch_pc. A further redirect while in DISCARD only updates fetch_pc.
- inst_valid = (count != 0). inst_data and inst_pc come from the FIFO head. Outputs are driven from registers only, with no combinational path from mem_* to inst_*.

## Timing
- Reset: state IDLE, count 0, fetch_pc RESET_PC, mem_req 0, inst_valid 0. inst_data and inst_pc read 0 while empty.
- rst asserted mid-request drops mem_req on the next cycle. A late mem_ack is ignored because IDLE does not sample ack. The memory must tolerate abandoned requests.
- The first mem_req is in the cycle after rst deasserts. An instruction acked in cycle N is visible at inst_valid in cycle N+1.
- For a redirect in cycle N with no outstanding request: mem_req to the new address in N+1; a same-cycle ack gives inst_valid in N+2.
- inst_valid is 0 in the cycle after a redirect, regardless of acks in that cycle.
- Steady-state zero-wait memory with a ready consumer sustains 1 instruction per cycle.

## Test plan
- Reset and stream: RESET_PC=0, zero-wait ack, inst_ready=1 → mem_addr 0,4,8,… on consecutive cycles; inst_pc/inst_data match, one per cycle from cycle 2 after reset.
- Back-pressure: inst_ready=0, DEPTH=4 → exactly 4 acks, then mem_req=0, count 4. Raising inst_ready yields PCs 0,4,8,12 in order, then fetch resumes at 16.
- Variable latency: ack after 3 wait cycles → mem_addr stable for all 4 req cycles; no duplicate or skipped PC.
- Redirect with outstanding request: redirect_pc=0x103 while waiting on 0x20 → state DISCARD; the 0x20 response is dropped; next mem_addr is 0x100; first inst_pc is 0x100.
- Redirect coincident with ack and pop: queue holds 3 entries, redirect to 0x40 → queue empty next cycle, acked word dropped, mem_addr 0x40 next cycle.
- Wrap and mid-op reset:
  - Redirect to 0xFFFF_FFFC → fetches 0xFFFF_FFFC then 0x0000_0000.
  - rst during a wait, with ack arriving later → ignored; fetch restarts at RESET_PC.
